// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulus counter family.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      v = v >> 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the cycle on which a step is taken.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          at_last;

  assign at_last = (pre_cnt_q == LAST);
  assign tick    = enable && !clear && at_last;

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear) begin
      pre_cnt_d = '0;
    end else if (enable) begin
      pre_cnt_d = at_last ? '0 : pre_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pre_cnt_q <= '0;
    else       pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down counter with modulus, load, wrap/saturate, prescaler,
// terminal-count pulse and sticky overflow.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH    = 4,
  parameter logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}},
  parameter int unsigned       PRESCALE = 1,
  parameter int unsigned       SATURATE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count_out,
  output logic             terminal,
  output logic             overflow,
  output logic             at_max,
  output logic             at_zero
);

  localparam mode_e MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] count_q, count_d;
  logic             terminal_q, terminal_d;
  logic             overflow_q, overflow_d;
  logic             tick;
  logic             boundary;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .clear (load),
    .tick  (tick)
  );

  always_comb begin
    count_d    = count_q;
    boundary   = 1'b0;
    overflow_d = overflow_q;
    if (load) begin
      count_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else if (tick) begin
      if (up_down == DIR_UP) begin
        if (count_q == MAX_VAL) begin
          boundary = 1'b1;
          count_d  = (MODE == MODE_SAT) ? MAX_VAL : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          boundary = 1'b1;
          count_d  = (MODE == MODE_SAT) ? '0 : MAX_VAL;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
    terminal_d = boundary;
    // Set dominates a simultaneous clear so no boundary event is lost.
    if (clear_ovf) overflow_d = 1'b0;
    if (boundary)  overflow_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      terminal_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      terminal_q <= terminal_d;
      overflow_q <= overflow_d;
    end
  end

  assign count_out = count_q;
  assign terminal  = terminal_q;
  assign overflow  = overflow_q;
  assign at_max    = (count_q == MAX_VAL);
  assign at_zero   = (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: four counter configurations share one stimulus stream.
module tb_updown_mod_counter;

  localparam int NI = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic       clear_ovf = 1'b0;

  logic [3:0] cnt_o   [NI];
  logic       term_o  [NI];
  logic       ovf_o   [NI];
  logic       amax_o  [NI];
  logic       azero_o [NI];

  int n_checks = 0;
  int n_fail   = 0;

  // Instance configs: 0 default, 1 MAX_VAL=9, 2 saturate, 3 PRESCALE=3
  function automatic int unsigned mx(input int i);
    return (i == 1) ? 9 : 15;
  endfunction
  function automatic int unsigned ps(input int i);
    return (i == 3) ? 3 : 1;
  endfunction
  function automatic bit st(input int i);
    return (i == 2);
  endfunction

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    updown_mod_counter #(
      .WIDTH   (4),
      .MAX_VAL (4'((g == 1) ? 9 : 15)),
      .PRESCALE((g == 3) ? 3 : 1),
      .SATURATE((g == 2) ? 1 : 0)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .up_down   (up_down),
      .load      (load),
      .load_value(load_value),
      .clear_ovf (clear_ovf),
      .count_out (cnt_o[g]),
      .terminal  (term_o[g]),
      .overflow  (ovf_o[g]),
      .at_max    (amax_o[g]),
      .at_zero   (azero_o[g])
    );
  end

  typedef struct packed {
    logic [3:0] cnt;
    logic       term;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  int unsigned m_cnt [NI];
  int unsigned m_pre [NI];
  logic        m_term[NI];
  logic        m_ovf [NI];
  int          cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_term[i] = 1'b0; m_ovf[i] = 1'b0;
    end
  endtask

  task automatic check_outputs(input exp_t e, input int i);
    check_val($sformatf("i%0d count", i), 32'(cnt_o[i]), 32'(e.cnt));
    check_val($sformatf("i%0d terminal", i), 32'(term_o[i]), 32'(e.term));
    check_val($sformatf("i%0d overflow", i), 32'(ovf_o[i]), 32'(e.ovf));
    check_val($sformatf("i%0d at_max", i), 32'(amax_o[i]), 32'(e.cnt == 4'(mx(i))));
    check_val($sformatf("i%0d at_zero", i), 32'(azero_o[i]), 32'(e.cnt == 4'd0));
  endtask

  task automatic drive(input logic en, input logic ud, input logic ld,
                       input logic [3:0] lv, input logic co);
    enable = en; up_down = ud; load = ld; load_value = lv; clear_ovf = co;
    for (int i = 0; i < NI; i++) begin
      bit ev;
      ev = 1'b0;
      if (ld) begin
        m_cnt[i]  = (32'(lv) > mx(i)) ? mx(i) : 32'(lv);
        m_pre[i]  = 0;
        m_term[i] = 1'b0;
      end else if (en) begin
        if (m_pre[i] == ps(i) - 1) begin
          m_pre[i] = 0;
          if (ud) begin
            if (m_cnt[i] == mx(i)) begin ev = 1'b1; m_cnt[i] = st(i) ? mx(i) : 0; end
            else m_cnt[i] = m_cnt[i] + 1;
          end else begin
            if (m_cnt[i] == 0) begin ev = 1'b1; m_cnt[i] = st(i) ? 0 : mx(i); end
            else m_cnt[i] = m_cnt[i] - 1;
          end
        end else begin
          m_pre[i] = m_pre[i] + 1;
        end
        m_term[i] = ev;
      end else begin
        m_term[i] = 1'b0;
      end
      if (co) m_ovf[i] = 1'b0;
      if (ev) m_ovf[i] = 1'b1;
      sb.push_back('{cnt: 4'(m_cnt[i]), term: m_term[i], ovf: m_ovf[i]});
    end
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      e = sb.pop_front();
      check_outputs(e, i);
    end
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input int ticks);
    exp_t z;
    z = '{cnt: 4'd0, term: 1'b0, ovf: 1'b0};
    #2;
    reset = 1'b1;
    enable = 1'b1; load = 1'b1; load_value = 4'd5;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) check_outputs(z, i);
    repeat (ticks) @(posedge clock);
    #1;
    for (int i = 0; i < NI; i++) check_outputs(z, i);
    #2;
    reset = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    exp_t z;
    z = '{cnt: 4'd0, term: 1'b0, ovf: 1'b0};
    model_reset();
    repeat (10) @(posedge clock);
    #1;
    for (int i = 0; i < NI; i++) check_outputs(z, i);
    #2;
    reset = 1'b0;

    // Count up through the wrap
    repeat (17) drive(1, 1, 0, 4'd0, 0);

    // Up to 7, then asynchronous reset mid-cycle, then resume
    async_reset(1);
    repeat (7) drive(1, 1, 0, 4'd0, 0);
    async_reset(3);
    repeat (4) drive(1, 1, 0, 4'd0, 0);

    // Down-count wrap from 0
    async_reset(1);
    repeat (13) drive(1, 0, 0, 4'd0, 0);

    // Load 14 then four up steps; saturating instance holds at 15
    drive(0, 1, 1, 4'd14, 0);
    repeat (4) drive(1, 1, 0, 4'd0, 0);
    drive(1, 0, 0, 4'd0, 1);
    drive(0, 0, 0, 4'd0, 0);

    // Prescaler timing with an enable gap mid-prescale
    async_reset(1);
    repeat (9) drive(1, 1, 0, 4'd0, 0);
    drive(1, 1, 0, 4'd0, 0);
    repeat (2) drive(0, 1, 0, 4'd0, 0);
    repeat (5) drive(1, 1, 0, 4'd0, 0);
    repeat (2) drive(1, 0, 0, 4'd0, 0);

    // Over-range load with enable high, then clear racing a boundary event
    drive(1, 1, 1, 4'd12, 0);
    drive(1, 1, 0, 4'd0, 1);
    drive(1, 1, 0, 4'd0, 0);
    drive(1, 0, 1, 4'd0, 0);
    drive(1, 0, 0, 4'd0, 1);

    // Mixed random traffic
    for (int k = 0; k < 80; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 7) == 0));
    end

    check_val("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
